// File: rtl/arbitro_pkg.sv
// ============================================================================
// Module      : arbitro_pkg
// Description : Shared types and constants for the arbitro_rr_4x1 arbiter:
//               FSM state encoding, channel count and select/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbitro_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/arbitro_rr_4x1_if.sv
// ============================================================================
// Module      : arbitro_rr_4x1_if
// Description : Flag/strobe bundle between the round-robin arbiter and its
//               input FIFOs, mux_4x1 and downstream FIFOs. The master modport
//               is the arbiter side, the slave modport the FIFO/mux side.
//               Macro ARB_GRANT_CNT_EN adds the grant counter bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arbitro_rr_4x1_if
`ifdef ARB_GRANT_CNT_EN
#(
    parameter int CNT_W = 8
)
`endif
();
    import arbitro_pkg::*;

    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] almost_full;
    logic [NUM_CH-1:0] pop;
    logic [SEL_W-1:0]  select;
    logic              push;
    state_t            state_o;
`ifdef ARB_GRANT_CNT_EN
    logic [NUM_CH*CNT_W-1:0] grant_cnt;
`endif

    modport master (
        input  fifo_empty,
        input  almost_full,
        output pop,
        output select,
        output push,
`ifdef ARB_GRANT_CNT_EN
        output grant_cnt,
`endif
        output state_o
    );

    modport slave (
        output fifo_empty,
        output almost_full,
        input  pop,
        input  select,
        input  push,
`ifdef ARB_GRANT_CNT_EN
        input  grant_cnt,
`endif
        input  state_o
    );

endinterface

`default_nettype wire

// File: rtl/arbitro_rr_pick.sv
// ============================================================================
// Module      : arbitro_rr_pick
// Description : Combinational rotate-priority finder. Returns the first set
//               request bit at or above ptr, wrapping from the top channel
//               back to channel 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr_pick
    import arbitro_pkg::*;
(
    input  wire logic [NUM_CH-1:0] req,
    input  wire logic [SEL_W-1:0]  ptr,
    output logic      [SEL_W-1:0]  gnt_idx,
    output logic                   gnt_vld
);

    logic [SEL_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_cand  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_cand = ptr + k[SEL_W-1:0];
            if (req[w_cand]) begin
                gnt_idx = w_cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_rr_4x1.sv
// ============================================================================
// Module      : arbitro_rr_4x1
// Description : Round-robin arbiter in front of mux_4x1. Grants at most one
//               non-empty input FIFO per cycle, never while any downstream
//               FIFO is almost full. pop/select/push are combinational from
//               the registered state and pointer plus the live flags.
//               Macro ARB_GRANT_CNT_EN adds per-channel grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr_4x1
    import arbitro_pkg::*;
#(
`ifdef ARB_GRANT_CNT_EN
    parameter int CNT_W  = 8,
`endif
    parameter int NUM_CH = 4
)
(
    input  wire logic        clk,
    input  wire logic        reset,
    arbitro_rr_4x1_if.master bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  w_ptr_nxt;

    logic [NUM_CH-1:0] w_req;
    logic              w_stall;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic              w_gnt_vld;

    logic [NUM_CH-1:0] w_pop;
    logic [SEL_W-1:0]  w_select;
    logic              w_push;

    assign w_req   = ~bus.fifo_empty;
    assign w_stall = |bus.almost_full;

    arbitro_rr_pick u_pick (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    // State and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RESET;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state and grant decode; stall is checked before any grant so a
    // flag rising in the sampled cycle still blocks the pop.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_pop       = '0;
        w_select    = '0;
        w_push      = 1'b0;
        unique case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_stall)
                    w_state_nxt = ST_PAUSE;
                else if (|w_req)
                    w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_stall) begin
                    w_state_nxt = ST_PAUSE;
                end else if (!w_gnt_vld) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pop     = NUM_CH'(1) << w_gnt_idx;
                    w_select  = w_gnt_idx;
                    w_push    = 1'b1;
                    w_ptr_nxt = w_gnt_idx + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (!w_stall)
                    w_state_nxt = (|w_req) ? ST_ACTIVE : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
        // Reset blanks the strobes in the same cycle so no partial grant leaks.
        if (reset) begin
            w_pop    = '0;
            w_select = '0;
            w_push   = 1'b0;
        end
    end

    assign bus.pop     = w_pop;
    assign bus.select  = w_select;
    assign bus.push    = w_push;
    assign bus.state_o = r_state;

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] r_cnt [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        // Per-channel grant counter; wraps naturally at 2^CNT_W.
        always_ff @(posedge clk) begin
            if (reset)
                r_cnt[g] <= '0;
            else if (w_pop[g])
                r_cnt[g] <= r_cnt[g] + 1'b1;
        end
        assign bus.grant_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_arbitro_rr_4x1.sv
// ============================================================================
// Module      : tb_arbitro_rr_4x1
// Description : Self-checking bench for arbitro_rr_4x1: per-cycle model
//               comparison plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_rr_4x1;

    localparam int TB_CNT_W = 2;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

`ifdef ARB_GRANT_CNT_EN
    arbitro_rr_4x1_if #(.CNT_W(TB_CNT_W)) u_if ();
    arbitro_rr_4x1 #(.CNT_W(TB_CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );
`else
    arbitro_rr_4x1_if u_if ();
    arbitro_rr_4x1 u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: 0=RESET 1=IDLE 2=ACTIVE 3=PAUSE
    int m_state, m_ptr, m_state_nxt, m_ptr_nxt;
    bit m_valid = 1'b0;
    int m_cnt [4];
    int m_gnt;   // channel granted in the current cycle, -1 if none

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model compare, away from the active edge.
    always @(negedge clk) begin
        int req, stall, e_pop, e_sel, e_push;
        req    = int'(~u_if.fifo_empty) & 15;
        stall  = (u_if.almost_full != 4'd0) ? 1 : 0;
        e_pop  = 0; e_sel = 0; e_push = 0; m_gnt = -1;
        m_state_nxt = m_state;
        m_ptr_nxt   = m_ptr;
        if (reset) begin
            m_state_nxt = 0;
            m_ptr_nxt   = 0;
        end else begin
            case (m_state)
                0: m_state_nxt = 1;
                1: m_state_nxt = stall ? 3 : (req != 0 ? 2 : 1);
                2: begin
                    if (stall) m_state_nxt = 3;
                    else if (req == 0) m_state_nxt = 1;
                    else begin
                        for (int k = 3; k >= 0; k--)
                            if ((req >> ((m_ptr + k) % 4)) & 1) m_gnt = (m_ptr + k) % 4;
                        e_pop = 1 << m_gnt; e_sel = m_gnt; e_push = 1;
                        m_ptr_nxt = (m_gnt + 1) % 4;
                    end
                end
                default: if (!stall) m_state_nxt = (req != 0) ? 2 : 1;
            endcase
        end
        if (m_valid) begin
            check("model_pop",    int'(u_if.pop),        e_pop);
            check("model_select", int'(u_if.select),     e_sel);
            check("model_push",   int'(u_if.push),       e_push);
            check("model_state",  int'(2'(u_if.state_o)), m_state);
`ifdef ARB_GRANT_CNT_EN
            for (int c = 0; c < 4; c++)
                check("model_cnt", int'(u_if.grant_cnt[c*TB_CNT_W +: TB_CNT_W]), m_cnt[c]);
`endif
        end
    end

    // Model state update at the active edge.
    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_ptr = 0; m_valid = 1'b1;
            for (int c = 0; c < 4; c++) m_cnt[c] = 0;
        end else if (m_valid) begin
            if (m_gnt >= 0) m_cnt[m_gnt] = (m_cnt[m_gnt] + 1) % (1 << TB_CNT_W);
            m_state = m_state_nxt;
            m_ptr   = m_ptr_nxt;
        end
    end

    task automatic step(input logic [3:0] e, input logic [3:0] af, input logic r);
        @(posedge clk);
        #1;
        u_if.fifo_empty  = e;
        u_if.almost_full = af;
        reset            = r;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int e_pop, input int e_sel,
                       input int e_push, input int e_state);
        check({name, "_pop"},    int'(u_if.pop),         e_pop);
        check({name, "_select"}, int'(u_if.select),      e_sel);
        check({name, "_push"},   int'(u_if.push),        e_push);
        check({name, "_state"},  int'(2'(u_if.state_o)), e_state);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        u_if.fifo_empty  = 4'h0;
        u_if.almost_full = 4'h0;

        // Reset with all channels requesting.
        step(4'h0, 4'h0, 1'b1); lit("rst1", 0, 0, 0, 0);
        step(4'h0, 4'h0, 1'b1); lit("rst2", 0, 0, 0, 0);
        step(4'h0, 4'h0, 1'b0); lit("rst_rel", 0, 0, 0, 0);
        step(4'h0, 4'h0, 1'b0); lit("idle", 0, 0, 0, 1);

        // All four requesting: strict rotation.
        for (int i = 0; i < 8; i++) begin
            step(4'h0, 4'h0, 1'b0);
            lit("rr_all", 1 << (i % 4), i % 4, 1, 2);
        end

        // Lone requester ch2, then ch3 is next after it.
        for (int i = 0; i < 3; i++) begin
            step(4'b1011, 4'h0, 1'b0); lit("lone2", 4'b0100, 2, 1, 2);
        end
        step(4'h0, 4'h0, 1'b0); lit("after_lone", 4'b1000, 3, 1, 2);

        // Stall for three cycles, grants resume at the saved pointer.
        step(4'h0, 4'h0, 1'b0); lit("pre_stall0", 1, 0, 1, 2);
        step(4'h0, 4'h0, 1'b0); lit("pre_stall1", 2, 1, 1, 2);
        step(4'h0, 4'b0100, 1'b0); lit("stall0", 0, 0, 0, 2);
        step(4'h0, 4'b0100, 1'b0); lit("stall1", 0, 0, 0, 3);
        step(4'h0, 4'b0100, 1'b0); lit("stall2", 0, 0, 0, 3);
        step(4'h0, 4'h0, 1'b0); lit("unstall", 0, 0, 0, 3);
        step(4'h0, 4'h0, 1'b0); lit("resume", 4, 2, 1, 2);
        step(4'h0, 4'h0, 1'b0); lit("resume3", 8, 3, 1, 2);
        step(4'h0, 4'h0, 1'b0); lit("resume0", 1, 0, 1, 2);
        step(4'h0, 4'h0, 1'b0); lit("resume1", 2, 1, 1, 2);

        // Reset mid-sequence with pointer at 2.
        step(4'h0, 4'h0, 1'b1); lit("mid_rst0", 0, 0, 0, 2);
        step(4'h0, 4'h0, 1'b1); lit("mid_rst1", 0, 0, 0, 0);
        step(4'h0, 4'h0, 1'b0); lit("mid_rel", 0, 0, 0, 0);
        step(4'h0, 4'h0, 1'b0); lit("mid_idle", 0, 0, 0, 1);
        step(4'h0, 4'h0, 1'b0); lit("mid_first", 1, 0, 1, 2);

        // Channel 1 goes empty after its turn would come: skipped.
        step(4'b0010, 4'h0, 1'b0); lit("skip1", 4, 2, 1, 2);
        step(4'hF, 4'h0, 1'b0);    lit("no_req", 0, 0, 0, 2);
        step(4'hF, 4'b0001, 1'b0); lit("idle_stall", 0, 0, 0, 1);
        step(4'hF, 4'h0, 1'b0);    lit("pause_noreq", 0, 0, 0, 3);
        step(4'h0, 4'h0, 1'b0);    lit("idle_req", 0, 0, 0, 1);
        step(4'h0, 4'h0, 1'b0);    lit("wrap3", 8, 3, 1, 2);

`ifdef ARB_GRANT_CNT_EN
        // Counter wrap on a lone channel 1 with a 2-bit counter.
        step(4'b1101, 4'h0, 1'b1);
        step(4'b1101, 4'h0, 1'b0);
        step(4'b1101, 4'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(4'b1101, 4'h0, 1'b0);
            check("cnt_ch1", int'(u_if.grant_cnt[TB_CNT_W +: TB_CNT_W]), k % 4);
        end
`endif

        step(4'hF, 4'h0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
